// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage controller.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [3:0] BE_WORD = 4'hF;
    localparam int         NLANES  = 4;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit data memory and the pipeline:
// byte enables, store-data replication and load-lane extraction.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]        lane,
    input  logic              byt,
    input  logic [XLEN-1:0]   st_data,
    input  logic [XLEN-1:0]   ld_raw,
    output logic [NLANES-1:0] be,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   ld_data
);

    // A byte store repeats the byte on every lane so the enable alone picks the target.
    always_comb begin
        be      = BE_WORD;
        wdata   = st_data;
        ld_data = ld_raw;
        if (byt) begin
            be      = 4'b0001 << lane;
            wdata   = {NLANES{st_data[7:0]}};
            ld_data = {{(XLEN-8){1'b0}}, ld_raw[8*lane +: 8]};
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory handshake FSM, load-data capture,
// MEM/WB register and stall-cycle counter.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   MEM_alu_out,
    input  logic [XLEN-1:0]   MEM_b2,
    input  logic [4:0]        MEM_rd,
    input  logic              MEM_we,
    input  logic              MEM_ld,
    input  logic              MEM_str,
    input  logic              MEM_byt,
    input  logic [XLEN-1:0]   MEM_link_addr,
    input  logic              MEM_link_we,
    output logic              MEM_stall,
    output logic              dmem_req,
    output logic              dmem_wr,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [NLANES-1:0] dmem_be,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ready,
    output logic [XLEN-1:0]   WB_data,
    output logic [4:0]        WB_rd,
    output logic              WB_we,
    output logic [31:0]       stall_cnt
);

    mem_state_t      state_q, state_d;
    logic            acc;
    logic            active;
    logic            mem_active;
    logic [XLEN-1:0] ld_raw_q;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wb_sel;
    logic            wb_en;

    assign acc = MEM_ld | MEM_str;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        active  = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    active  = 1'b1;
                    state_d = dmem_ready ? DONE : BUSY;
                end
            end
            BUSY: begin
                active = 1'b1;
                if (dmem_ready) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gating with rst drops the request at once, even though inputs still ask for an access.
    assign mem_active = active & ~rst;
    assign MEM_stall  = mem_active;
    assign dmem_req   = mem_active;
    assign dmem_wr    = mem_active & MEM_str & ~MEM_ld;
    assign dmem_addr  = {MEM_alu_out[XLEN-1:2], 2'b00};

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .lane    (MEM_alu_out[1:0]),
        .byt     (MEM_byt),
        .st_data (MEM_b2),
        .ld_raw  (ld_raw_q),
        .be      (dmem_be),
        .wdata   (dmem_wdata),
        .ld_data (ld_data)
    );

    always_comb begin
        wb_sel = MEM_alu_out;
        if (MEM_link_we)  wb_sel = MEM_link_addr;
        else if (MEM_ld)  wb_sel = ld_data;
        wb_en = (MEM_we | MEM_link_we) & (MEM_rd != 5'd0);
    end

    // Read data is kept until the DONE cycle, when the aligned value enters MEM/WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_raw_q  <= '0;
            WB_data   <= '0;
            WB_rd     <= '0;
            WB_we     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (mem_active && dmem_ready) ld_raw_q <= dmem_rdata;
            if (!mem_active) begin
                WB_data <= wb_sel;
                WB_rd   <= MEM_rd;
                WB_we   <= wb_en;
            end else begin
                WB_we   <= 1'b0;
            end
            if (mem_active && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
